// File: rtl/mem_bus_pkg.sv
// Shared widths, FSM state encoding and latched request layout for the
// CPU memory-port bus interface.
package mem_bus_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 4;
    localparam int WAIT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD,
        HIT
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/bus_line_cache.sv
// One-entry read cache: tag/data/valid with lookup, fill on read completion
// and write-through update when a write lands on the cached address.
module bus_line_cache #(
    parameter int ADDR_W   = mem_bus_pkg::ADDR_W,
    parameter int DATA_W   = mem_bus_pkg::DATA_W,
    parameter int CACHE_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_lookup_addr,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_fill_en,
    input  logic [ADDR_W-1:0] i_fill_addr,
    input  logic [DATA_W-1:0] i_fill_data,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data
);
    import mem_bus_pkg::*;

    logic              r_valid;
    logic [ADDR_W-1:0] r_tag;
    logic [DATA_W-1:0] r_data;

    assign o_hit  = (CACHE_EN != 0) && r_valid && (r_tag == i_lookup_addr);
    assign o_data = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (i_fill_en) begin
            r_valid <= 1'b1;
            r_tag   <= i_fill_addr;
            r_data  <= i_fill_data;
        end else if (i_wr_en && r_valid && (r_tag == i_wr_addr)) begin
            r_data  <= i_wr_data;
        end
    end

endmodule

// File: rtl/mem_bus_if.sv
// Bus interface unit: one core request at a time, sequenced onto the address,
// data and direction pins with programmable wait states and a read cache.
module mem_bus_if #(
    parameter int ADDR_W      = mem_bus_pkg::ADDR_W,
    parameter int DATA_W      = mem_bus_pkg::DATA_W,
    parameter int WAIT_STATES = 2,
    parameter int CACHE_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data_out,
    input  logic [DATA_W-1:0] bus_data_in,
    output logic              bus_data_rw
);
    import mem_bus_pkg::*;

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);

    state_t              r_state;
    req_t                r_req;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [DATA_W-1:0]   r_bus_data_out;
    logic                r_bus_data_rw;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_ack;

    logic                w_hit;
    logic [DATA_W-1:0]   w_cache_data;
    logic                w_fill_en;
    logic                w_wt_en;

    // Cache updates coincide with the HOLD exit edge, using the captured read data.
    assign w_fill_en = (r_state == HOLD) && !r_req.we;
    assign w_wt_en   = (r_state == HOLD) &&  r_req.we;

    bus_line_cache #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .CACHE_EN (CACHE_EN)
    ) u_cache (
        .clk           (clk),
        .rst           (rst),
        .i_lookup_addr (addr),
        .o_hit         (w_hit),
        .o_data        (w_cache_data),
        .i_fill_en     (w_fill_en),
        .i_fill_addr   (r_req.addr),
        .i_fill_data   (r_rdata),
        .i_wr_en       (w_wt_en),
        .i_wr_addr     (r_req.addr),
        .i_wr_data     (r_req.wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_req          <= '0;
            r_wait_cnt     <= '0;
            r_bus_addr     <= '0;
            r_bus_data_out <= '0;
            r_bus_data_rw  <= 1'b0;
            r_rdata        <= '0;
            r_ack          <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_req.we    <= we;
                        r_req.addr  <= addr;
                        r_req.wdata <= wdata;
                        r_state     <= (!we && w_hit) ? HIT : SETUP;
                    end
                end
                SETUP: begin
                    r_bus_addr <= r_req.addr;
                    if (r_req.we) begin
                        r_bus_data_out <= r_req.wdata;
                        r_bus_data_rw  <= 1'b1;
                    end else begin
                        r_bus_data_rw  <= 1'b0;
                    end
                    r_wait_cnt <= WAIT_LOAD;
                    r_state    <= ACCESS;
                end
                ACCESS: begin
                    if (r_wait_cnt != '0) begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end else begin
                        if (!r_req.we) begin
                            r_rdata <= bus_data_in;
                        end
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    r_bus_data_rw <= 1'b0;
                    r_ack         <= 1'b1;
                    r_state       <= IDLE;
                end
                HIT: begin
                    r_rdata <= w_cache_data;
                    r_ack   <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rdata        = r_rdata;
    assign ack          = r_ack;
    assign busy         = (r_state != IDLE);
    assign bus_addr     = r_bus_addr;
    assign bus_data_out = r_bus_data_out;
    assign bus_data_rw  = r_bus_data_rw;

endmodule
